// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM port between ifetch (m0) and data (m1).
// Build option ARB_RR_EN: round-robin on contention, else m1 has priority.
module sram_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_ce_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    input  logic [3:0]        m0_sel_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_ce_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    input  logic [3:0]        m1_sel_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_data_o,
    output logic [3:0]        sram_sel_o,
    input  logic              sram_ready_i,
    input  logic [DATA_W-1:0] sram_data_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(TIMEOUT - 1);

    logic [1:0]        state;
    logic              owner;
    logic [TO_W-1:0]   cnt;
    logic              armed0;
    logic              armed1;
    logic              elig0;
    logic              elig1;
    logic              pick1;
    logic              done_ok;
    logic              done_to;
    logic              done;
    logic [DATA_W-1:0] rdata;

`ifdef ARB_RR_EN
    logic last_grant;
`endif

    assign elig0 = m0_ce_i && armed0;
    assign elig1 = m1_ce_i && armed1;

    assign done_ok = (state == S_BUSY) && sram_ready_i;
    assign done_to = (state == S_BUSY) && !sram_ready_i
                  && (TIMEOUT != 0) && (cnt == TO_LAST);
    assign done    = done_ok || done_to;

    // writes and timeouts hand back zero
    assign rdata = (done_ok && !sram_we_o) ? sram_data_i : '0;

    // choose m1 when it asks, unless round robin says m0's turn
    always_comb begin
        pick1 = elig1;
`ifdef ARB_RR_EN
        if (elig0 && elig1) begin
            pick1 = !last_grant;
        end
`endif
    end

`ifdef ARB_RR_EN
    // remember who last finished normally (1 = m1)
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (done_ok) begin
            last_grant <= owner;
        end
    end
`endif

    // one grant per ce assertion: disarm on ack, re-arm when ce drops
    always_ff @(posedge clk) begin
        if (!rst) begin
            armed0 <= 1'b1;
            armed1 <= 1'b1;
        end else begin
            if (!m0_ce_i) begin
                armed0 <= 1'b1;
            end else if (done && !owner) begin
                armed0 <= 1'b0;
            end
            if (!m1_ce_i) begin
                armed1 <= 1'b1;
            end else if (done && owner) begin
                armed1 <= 1'b0;
            end
        end
    end

    // grant, hold the SRAM request, complete or time out, then gap a cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            cnt         <= '0;
            sram_ce_o   <= 1'b0;
            sram_we_o   <= 1'b0;
            sram_addr_o <= '0;
            sram_data_o <= '0;
            sram_sel_o  <= '0;
            m0_data_o   <= '0;
            m0_ack_o    <= 1'b0;
            m0_err_o    <= 1'b0;
            m1_data_o   <= '0;
            m1_ack_o    <= 1'b0;
            m1_err_o    <= 1'b0;
        end else begin
            m0_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m1_err_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (elig0 || elig1) begin
                        sram_we_o   <= pick1 ? m1_we_i   : m0_we_i;
                        sram_addr_o <= pick1 ? m1_addr_i : m0_addr_i;
                        sram_data_o <= pick1 ? m1_data_i : m0_data_i;
                        sram_sel_o  <= pick1 ? m1_sel_i  : m0_sel_i;
                        sram_ce_o   <= 1'b1;
                        owner       <= pick1;
                        cnt         <= '0;
                        state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (done) begin
                        if (owner) begin
                            m1_ack_o  <= 1'b1;
                            m1_err_o  <= done_to;
                            m1_data_o <= rdata;
                        end else begin
                            m0_ack_o  <= 1'b1;
                            m0_err_o  <= done_to;
                            m0_data_o <= rdata;
                        end
                        sram_ce_o <= 1'b0;
                        state     <= S_REL;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_REL: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
